// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and typedefs for pipeline stages
package regfile_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;
    localparam int ZERO_REG_IDX = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/register.sv
// rtl/register.sv - single storage word with load enable and asynchronous clear
module register
    import regfile_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             wenable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (wenable) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multi-port register file with write priority, bypass and busy scoreboard
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int N        = REG_ADDR_W,
    parameter int WIDTH    = XLEN,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NWRITE-1:0]             wenable,
    input  logic [NWRITE-1:0][N-1:0]      reg_in,
    input  logic [NWRITE-1:0][WIDTH-1:0]  din,
    input  logic [NREAD-1:0][N-1:0]       raddr,
    output logic [NREAD-1:0][WIDTH-1:0]   rdata,
    output logic [NREAD-1:0]              rbusy,
    input  logic                          busy_set,
    input  logic [N-1:0]                  busy_reg,
    output logic [(2**N)-1:0]             busy_vec
);

    localparam int NREG = 1 << N;

    logic [NREG-1:0]  whit;
    logic [WIDTH-1:0] wsel   [NREG];
    logic [WIDTH-1:0] stored [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_word
            logic             hit;
            logic [WIDTH-1:0] data;

            // Later ports overwrite earlier matches, so the highest-indexed port wins.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                for (int p = 0; p < NWRITE; p++) begin
                    if (wenable[p] && (reg_in[p] == N'(g))) begin
                        hit  = 1'b1;
                        data = din[p];
                    end
                end
                if (ZERO_REG && (g == ZERO_REG_IDX)) begin
                    hit = 1'b0;
                end
            end

            assign whit[g] = hit;
            assign wsel[g] = data;

            register #(
                .WIDTH (WIDTH)
            ) u_reg (
                .rst     (rst),
                .clk     (clk),
                .wenable (hit),
                .din     (data),
                .dout    (stored[g])
            );
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NREAD; i++) begin : g_read
            logic [WIDTH-1:0] rd;
            logic             rb;

            always_comb begin
                rd = stored[raddr[i]];
                rb = busy_q[raddr[i]];
                if (BYPASS && whit[raddr[i]]) begin
                    rd = wsel[raddr[i]];
                    rb = 1'b0;
                end
                if (ZERO_REG && (raddr[i] == N'(ZERO_REG_IDX))) begin
                    rd = '0;
                    rb = 1'b0;
                end
                // Bypass paths would otherwise leak din while the file is held in reset.
                if (rst) begin
                    rd = '0;
                    rb = 1'b0;
                end
            end

            assign rdata[i] = rd;
            assign rbusy[i] = rb;
        end
    endgenerate

    // Retiring writes clear first; a new producer marked the same cycle takes precedence.
    always_comb begin
        busy_d = busy_q & ~whit;
        if (busy_set && !(ZERO_REG && (busy_reg == N'(ZERO_REG_IDX)))) begin
            busy_d[busy_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - scoreboard bench for multiport_regfile, bypass and non-bypass instances
module tb_multiport_regfile;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int NR   = 3;
    localparam int NW   = 2;
    localparam int NREG = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NW-1:0]         we;
    logic [NW-1:0][N-1:0]  wa;
    logic [NW-1:0][W-1:0]  wd;
    logic [NR-1:0][N-1:0]  ra;
    logic                  bset;
    logic [N-1:0]          breg;

    logic [NR-1:0][W-1:0]  rd_b, rd_n;
    logic [NR-1:0]         rb_b, rb_n;
    logic [NREG-1:0]       bv_b, bv_n;

    typedef struct {
        logic [NR-1:0][W-1:0] rd_b;
        logic [NR-1:0][W-1:0] rd_n;
        logic [NR-1:0]        rb_b;
        logic [NR-1:0]        rb_n;
        logic [NREG-1:0]      bv;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    string tag;

    int unsigned mem  [NREG];
    bit          busy [NREG];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiport_regfile #(
        .N(N), .WIDTH(W), .NREAD(NR), .NWRITE(NW), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .wenable(we), .reg_in(wa), .din(wd), .raddr(ra),
        .rdata(rd_b), .rbusy(rb_b), .busy_set(bset), .busy_reg(breg), .busy_vec(bv_b)
    );

    multiport_regfile #(
        .N(N), .WIDTH(W), .NREAD(NR), .NWRITE(NW), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_n (
        .clk(clk), .rst(rst), .wenable(we), .reg_in(wa), .din(wd), .raddr(ra),
        .rdata(rd_n), .rbusy(rb_n), .busy_set(bset), .busy_reg(breg), .busy_vec(bv_n)
    );

    function automatic exp_t predict();
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            int a;
            int w;
            int unsigned stv;
            a   = int'(ra[i]);
            w   = -1;
            for (int p = 0; p < NW; p++) begin
                if (we[p] && int'(wa[p]) == a) w = p;
            end
            stv = (a == 0) ? 0 : mem[a];
            e.rd_n[i] = stv;
            e.rb_n[i] = busy[a];
            if (w >= 0 && a != 0) begin
                e.rd_b[i] = wd[w];
                e.rb_b[i] = 1'b0;
            end else begin
                e.rd_b[i] = stv;
                e.rb_b[i] = busy[a];
            end
        end
        for (int r = 0; r < NREG; r++) e.bv[r] = busy[r];
        if (rst) begin
            e.rd_b = '0;
            e.rd_n = '0;
            e.rb_b = '0;
            e.rb_n = '0;
            e.bv   = '0;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            mem[r]  = 0;
            busy[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int p = 0; p < NW; p++) begin
            if (we[p] && wa[p] != 0) begin
                mem[wa[p]]  = wd[p];
                busy[wa[p]] = 1'b0;
            end
        end
        if (bset && breg != 0) busy[breg] = 1'b1;
    endtask

    task automatic step(input bit do_rst);
        if (do_rst) begin
            #1 rst = 1'b1;
            model_reset();
        end
        exp_q.push_back(predict());
        tag_q.push_back(tag);
        if (!rst) model_update();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle();
        we   = '0;
        wa   = '0;
        wd   = '0;
        bset = 1'b0;
        breg = '0;
    endtask

    task automatic chk(input string t, input string what, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", t, what, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, "bypass rdata",   128'(rd_b), 128'(e.rd_b));
            chk(t, "bypass rbusy",   128'(rb_b), 128'(e.rb_b));
            chk(t, "bypass busy_vec", 128'(bv_b), 128'(e.bv));
            chk(t, "plain rdata",    128'(rd_n), 128'(e.rd_n));
            chk(t, "plain rbusy",    128'(rb_n), 128'(e.rb_n));
            chk(t, "plain busy_vec", 128'(bv_n), 128'(e.bv));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        ra = '0;
        model_reset();
        tag = "reset";
        @(posedge clk);
        #1;
        exp_q.push_back(predict());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tag = "rst_write";
        idle(); we[0] = 1'b1; wa[0] = 4'd5; wd[0] = 32'hDEADBEEF; ra = {4'd5, 4'd5, 4'd5};
        step(0);
        idle(); bset = 1'b1; breg = 4'd2;
        step(0);
        idle();
        step(0);
        tag = "rst_mid";
        step(1);
        tag = "rst_after";
        step(0);

        tag = "raw_r7";
        idle(); we[0] = 1'b1; wa[0] = 4'd7; wd[0] = 32'h12345678; ra = {4'd1, 4'd7, 4'd7};
        step(0);
        idle();
        step(0);

        tag = "bypass_r3";
        idle(); we[0] = 1'b1; wa[0] = 4'd3; wd[0] = 32'hA5A5A5A5; ra = {4'd3, 4'd3, 4'd3};
        step(0);
        tag = "write_r0";
        idle(); we[1] = 1'b1; wa[1] = 4'd0; wd[1] = 32'h1; ra = {4'd0, 4'd0, 4'd3};
        step(0);
        idle();
        step(0);

        tag = "prio_r9";
        idle(); we = 2'b11; wa = {4'd9, 4'd9}; wd = {32'h222, 32'h111}; ra = {4'd9, 4'd9, 4'd9};
        step(0);
        tag = "dual_r4_r6";
        idle(); we = 2'b11; wa = {4'd6, 4'd4}; wd = {32'h6666, 32'h4444}; ra = {4'd9, 4'd6, 4'd4};
        step(0);
        idle();
        step(0);

        tag = "busy_set_r10";
        idle(); bset = 1'b1; breg = 4'd10; ra = {4'd10, 4'd10, 4'd10};
        step(0);
        tag = "busy_set_and_write";
        idle(); we[0] = 1'b1; wa[0] = 4'd10; wd[0] = 32'hABCD; bset = 1'b1; breg = 4'd10;
        step(0);
        tag = "busy_held";
        idle();
        step(0);
        tag = "busy_clear";
        idle(); we[1] = 1'b1; wa[1] = 4'd10; wd[1] = 32'hBEEF;
        step(0);
        idle();
        step(0);
        tag = "busy_r0";
        idle(); bset = 1'b1; breg = 4'd0; ra = {4'd0, 4'd10, 4'd0};
        step(0);
        idle();
        step(0);

        tag = "random";
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < NW; p++) begin
                we[p] = 1'($urandom_range(0, 1));
                wa[p] = N'($urandom_range(0, NREG - 1));
                wd[p] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0) ra[i] = wa[$urandom_range(0, 1)];
                else ra[i] = N'($urandom_range(0, NREG - 1));
            end
            bset = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) breg = wa[0];
            else breg = N'($urandom_range(0, NREG - 1));
            step($urandom_range(0, 499) == 0);
        end

        idle();
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised successor to the single-write/dual-read integer register file: 2**N registers of WIDTH bits, NREAD combinational read ports, NWRITE write ports with fixed priority, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. It sits between decode (reads and busy set) and writeback (writes and busy clear) in the pipeline. Register 0 can be hardwired to zero.

## Interface

Parameters:
- N, 5, address bits; 2**N registers
- WIDTH, 32, bits per register
- NREAD, 2, number of read ports (1..8)
- NWRITE, 1, number of write ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = read returns stored value
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wenable  in  NWRITE  per-port write enable
- reg_in  in  NWRITE×N  per-port write address, packed [NWRITE-1:0][N-1:0]
- din  in  NWRITE×WIDTH  per-port write data
- raddr  in  NREAD×N  read addresses
- rdata  out  NREAD×WIDTH  read data
- rbusy  out  NREAD  busy flag for each read address
- busy_set  in  1  mark register busy_reg as having a pending producer
- busy_reg  in  N  register to mark
- busy_vec  out  2**N  full scoreboard state, for debug and stall logic

## Operation

- Storage: 2**N×WIDTH flops; busy: 2**N flops.
- Write: on rising clk, for each register r, the highest-indexed port p with wenable[p] && reg_in[p]==r writes din[p]. Lower-indexed ports matching the same r are dropped.
- ZERO_REG=1: writes to r0 discarded, busy_set to r0 ignored, rdata for address 0 is 0 even if bypassing, rbusy for r0 is 0.
- Read: rdata[i] is combinational from raddr[i]. With BYPASS=1 and a same-cycle enabled write to raddr[i], rdata[i] = din of the winning port; otherwise the stored value.
- Busy: any enabled write to r clears busy[r] at the edge; busy_set sets busy[busy_reg]. If a set and a clear hit the same register in the same cycle, set wins (a new producer supersedes the retiring one).
- rbusy[i] = busy[raddr[i]], except with BYPASS=1 it is 0 when a same-cycle enabled write targets raddr[i]. A same-cycle busy_set does not affect rbusy until the next cycle.
- Addresses are always in range, since 2**N entries cover every N-bit address. No X propagation for any input combination.

## Timing

- Reset: asynchronous; all registers and busy bits go to 0 immediately. rdata = 0, rbusy = 0, busy_vec = 0 while rst is high and after it is released. A write coinciding with reset is lost.
- Write latency: 1 cycle to storage. Read-after-write is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- busy_set is visible on busy_vec and rbusy from the next cycle.
- Reset asserted mid-stream clears pending busy bits. Upstream must flush in-flight producers on the same reset.
- All outputs are combinational functions of state and the current inputs. No handshake and no backpressure: the block always accepts writes.

## Structure

- Shared package regfile_pkg: default constants (REG_ADDR_W=5, XLEN=32, ZERO_REG index 0) and typedefs reg_addr_t and xlen_t. Other pipeline stages import these.
- One sub-module per storage word: reuse the existing `register` block (rst, clk, wenable, din, dout), instantiated as a 2**N array.
- A per-register write-select mux picks din from the winning port and drives that register's wenable.
- Busy scoreboard: a flat 2**N vector in this module with no sub-module.
- Bypass and priority logic: generate loops over NREAD and NWRITE.

## Test plan

- Reset: write 0xDEADBEEF to r5, then pulse rst asynchronously mid-cycle -> rdata for r5 = 0 immediately, busy_vec = 0.
- Write then read, BYPASS=0: write 0x12345678 to r7, raddr[0]=7 in the same cycle -> rdata[0] = old value 0, and 0x12345678 from the next cycle.
- Bypass, BYPASS=1, NREAD=3: write 0xA5A5A5A5 to r3, all raddr=3 -> all rdata = 0xA5A5A5A5 in the same cycle. Write 0x1 to r0 -> rdata for address 0 = 0.
- Priority, NWRITE=2: port0 writes 0x111 and port1 writes 0x222 to r9 in the same cycle -> r9 = 0x222. Both ports targeting different registers (r4, r6) -> both written.
- Scoreboard: busy_set r10 -> busy_vec[10]=1 next cycle and rbusy=1 for raddr=10. Write to r10 with busy_set r10 in the same cycle -> stays busy. Write alone -> clears, and rbusy=0 in the write cycle when BYPASS=1.
- Random regression vs. reference model: 10k cycles with random enables and addresses including r0 and collisions -> rdata, rbusy and busy_vec match every cycle.
